// File: rtl/rx_word_packer.sv
// rx_word_packer: packs four UART bytes (first byte in [31:24]) into a 32-bit word.
// The word is tagged with an auto-incrementing byte address and offered over valid/ready.
// An END_WORD transfer stops loading. A word completed while the slot is busy is dropped
// and sets the sticky overrun flag.
// Optional inter-byte timeout: define RX_WORD_TIMEOUT_EN.
module rx_word_packer #(
    parameter int unsigned N_BITS_DATA    = 8,
    parameter int unsigned ADDR_W         = 10,
    parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [N_BITS_DATA-1:0] data_i,
    input  logic                   clear_i,
    input  logic                   word_ready_i,
    output logic                   word_valid_o,
    output logic [31:0]            word_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   done_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    // The packing arithmetic assumes 8-bit bytes, and the timeout needs at least two cycles.
    if (N_BITS_DATA != 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("rx_word_packer: N_BITS_DATA must be 8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    // Only the first three bytes need storage; the fourth arrives with the completing tick.
    logic [23:0]       shift_q;

    logic        accept;
    logic        complete;
    logic        slot_free;
    logic [31:0] full_word;

    assign accept    = rx_done_tick && (state_q != StDone);
    assign complete  = accept && (byte_cnt_q == 2'd3);
    assign slot_free = !word_valid_o || word_ready_i;
    assign full_word = {shift_q, data_i};

`ifdef RX_WORD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Byte collection FSM, output slot handshake, status flags and optional timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            byte_cnt_q   <= 2'd0;
            addr_cnt_q   <= '0;
            shift_q      <= '0;
            word_valid_o <= 1'b0;
            word_o       <= '0;
            addr_o       <= '0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_o    <= 1'b0;
`endif
        end else if (clear_i) begin
            // Restart wins over any tick or pending word in the same cycle.
            state_q      <= StIdle;
            byte_cnt_q   <= 2'd0;
            addr_cnt_q   <= '0;
            word_valid_o <= 1'b0;
            done_o       <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_o    <= 1'b0;
`endif
        end else begin
            if (word_valid_o && word_ready_i) begin
                word_valid_o <= 1'b0;
                // In StDone the slot can only hold the end word.
                if (state_q == StDone) begin
                    done_o <= 1'b1;
                end
            end

            if (accept) begin
                shift_q <= {shift_q[15:0], data_i};
                if (complete) begin
                    byte_cnt_q <= 2'd0;
                    state_q    <= StIdle;
                    if (slot_free) begin
                        word_o       <= full_word;
                        addr_o       <= addr_cnt_q;
                        word_valid_o <= 1'b1;
                        addr_cnt_q   <= addr_cnt_q + ADDR_W'(4);
                        if (full_word == END_WORD) begin
                            state_q <= StDone;
                        end
                    end else begin
                        overrun_o <= 1'b1;
                    end
                end else begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    state_q    <= StCollect;
                end
            end

`ifdef RX_WORD_TIMEOUT_EN
            timeout_o <= 1'b0;
            if (accept) begin
                to_cnt_q <= '0;
            end else if (state_q == StCollect) begin
                if (to_cnt_q == TO_LAST) begin
                    // Discard the partial word; the address is unaffected.
                    to_cnt_q   <= '0;
                    byte_cnt_q <= 2'd0;
                    state_q    <= StIdle;
                    timeout_o  <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed self-checking bench for rx_word_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rx_word_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_done_tick;
    logic [7:0]  data_i;
    logic        clear_i;
    logic        word_ready_i;
    logic        word_valid_o;
    logic [31:0] word_o;
    logic [9:0]  addr_o;
    logic        done_o;
    logic        overrun_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    rx_word_packer #(
        .N_BITS_DATA   (8),
        .ADDR_W        (10),
        .END_WORD      (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .data_i      (data_i),
        .clear_i     (clear_i),
        .word_ready_i(word_ready_i),
        .word_valid_o(word_valid_o),
        .word_o      (word_o),
        .addr_o      (addr_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    // One-cycle tick; returns on the falling edge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        data_i       = b;
        @(negedge clock);
        rx_done_tick = 1'b0;
    endtask

    task automatic do_clear;
        clear_i = 1'b1;
        @(negedge clock);
        clear_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; rx_done_tick = 1'b0; data_i = 8'h00; clear_i = 1'b0; word_ready_i = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (word_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b required 0", word_valid_o); end
        checks++; if (word_o !== 32'h0) begin errors++;
            $display("FAIL reset_word: got %h required 00000000", word_o); end
        checks++; if (addr_o !== 10'h0) begin errors++;
            $display("FAIL reset_addr: got %h required 000", addr_o); end
        checks++; if ({done_o, overrun_o, timeout_o} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b required 000", {done_o, overrun_o, timeout_o}); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic;
        word_ready_i = 1'b1;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        checks++; if (word_valid_o !== 1'b1) begin errors++;
            $display("FAIL basic_valid0: got %b required 1", word_valid_o); end
        checks++; if (word_o !== 32'h1234_5678) begin errors++;
            $display("FAIL basic_word0: got %h required 12345678", word_o); end
        checks++; if (addr_o !== 10'd0) begin errors++;
            $display("FAIL basic_addr0: got %0d required 0", addr_o); end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        checks++; if (word_o !== 32'hAABB_CCDD) begin errors++;
            $display("FAIL basic_word1: got %h required aabbccdd", word_o); end
        checks++; if (addr_o !== 10'd4) begin errors++;
            $display("FAIL basic_addr1: got %0d required 4", addr_o); end
        @(negedge clock);
        checks++; if (word_valid_o !== 1'b0) begin errors++;
            $display("FAIL basic_valid_fall: got %b required 0", word_valid_o); end
        checks++; if ({done_o, overrun_o} !== 2'b00) begin errors++;
            $display("FAIL basic_flags: got %b required 00", {done_o, overrun_o}); end
    endtask

    task automatic test_overrun;
        word_ready_i = 1'b0;
        do_clear();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        checks++; if ({word_valid_o, overrun_o} !== 2'b10) begin errors++;
            $display("FAIL ovr_first: got valid/ovr %b required 10", {word_valid_o, overrun_o}); end
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        checks++; if (overrun_o !== 1'b1) begin errors++;
            $display("FAIL ovr_set: got %b required 1", overrun_o); end
        checks++; if (word_o !== 32'h0102_0304 || addr_o !== 10'd0) begin errors++;
            $display("FAIL ovr_hold: got %h@%0d required 01020304@0", word_o, addr_o); end
        word_ready_i = 1'b1;
        @(negedge clock);
        checks++; if (word_valid_o !== 1'b0) begin errors++;
            $display("FAIL ovr_xfer: got valid %b required 0", word_valid_o); end
        repeat (3) @(negedge clock);
        checks++; if (overrun_o !== 1'b1) begin errors++;
            $display("FAIL ovr_sticky: got %b required 1", overrun_o); end
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        checks++; if (word_o !== 32'h0A0B_0C0D || addr_o !== 10'd4) begin errors++;
            $display("FAIL ovr_next: got %h@%0d required 0a0b0c0d@4", word_o, addr_o); end
    endtask

    task automatic test_end_of_program;
        word_ready_i = 1'b1;
        do_clear();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        checks++; if (word_o !== 32'h1 || addr_o !== 10'd0 || word_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL eop_first: got %h@%0d v%b required 00000001@0 v1",
                     word_o, addr_o, word_valid_o);
        end
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        checks++; if (word_o !== 32'hFFFF_FFFF || addr_o !== 10'd4 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL eop_end: got %h@%0d done%b required ffffffff@4 done0",
                     word_o, addr_o, done_o);
        end
        @(negedge clock);
        checks++; if ({word_valid_o, done_o} !== 2'b01) begin errors++;
            $display("FAIL eop_done: got valid/done %b required 01", {word_valid_o, done_o}); end
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        @(negedge clock);
        checks++; if ({word_valid_o, done_o} !== 2'b01) begin errors++;
            $display("FAIL eop_ignore: got valid/done %b required 01", {word_valid_o, done_o}); end
    endtask

    task automatic test_clear_in_done;
        word_ready_i = 1'b0;
        do_clear();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        word_ready_i = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        @(negedge clock);
        checks++; if ({done_o, overrun_o} !== 2'b11) begin errors++;
            $display("FAIL clr_pre: got done/ovr %b required 11", {done_o, overrun_o}); end
        clear_i = 1'b1; rx_done_tick = 1'b1; data_i = 8'h55;
        @(negedge clock);
        clear_i = 1'b0; rx_done_tick = 1'b0;
        checks++; if ({word_valid_o, done_o, overrun_o} !== 3'b000) begin errors++;
            $display("FAIL clr_flags: got valid/done/ovr %b required 000",
                     {word_valid_o, done_o, overrun_o});
        end
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++; if (word_o !== 32'h0102_0304 || addr_o !== 10'd0 || word_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_word: got %h@%0d v%b required 01020304@0 v1",
                     word_o, addr_o, word_valid_o);
        end
    endtask

    task automatic test_reset_mid_word;
        word_ready_i = 1'b0;
        do_clear();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++; if (word_valid_o !== 1'b1 || word_o !== 32'h1122_3344) begin errors++;
            $display("FAIL rst_pre: got %h v%b required 11223344 v1", word_o, word_valid_o); end
        send_byte(8'hAA); send_byte(8'hBB);
        #2 reset = 1'b0;
        #1;
        checks++; if ({word_valid_o, done_o, overrun_o, timeout_o} !== 4'b0000 ||
                      word_o !== 32'h0 || addr_o !== 10'd0) begin
            errors++;
            $display("FAIL rst_async: got %h@%0d flags %b required 00000000@0 flags 0000",
                     word_o, addr_o, {word_valid_o, done_o, overrun_o, timeout_o});
        end
        @(negedge clock);
        reset = 1'b1;
        word_ready_i = 1'b1;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++; if (word_o !== 32'hDEAD_BEEF || addr_o !== 10'd0 || word_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_word: got %h@%0d v%b required deadbeef@0 v1",
                     word_o, addr_o, word_valid_o);
        end
    endtask

`ifdef RX_WORD_TIMEOUT_EN
    task automatic test_timeout;
        int early;
        word_ready_i = 1'b1;
        do_clear();
        send_byte(8'h12);
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (timeout_o !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++;
            $display("FAIL to_early: got %0d early pulses required 0", early); end
        @(negedge clock);
        checks++; if (timeout_o !== 1'b1) begin errors++;
            $display("FAIL to_pulse: got %b required 1", timeout_o); end
        @(negedge clock);
        checks++; if (timeout_o !== 1'b0) begin errors++;
            $display("FAIL to_one_cycle: got %b required 0", timeout_o); end
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        checks++; if (word_o !== 32'h9ABC_DEF0 || addr_o !== 10'd0 || word_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL to_word: got %h@%0d v%b required 9abcdef0@0 v1",
                     word_o, addr_o, word_valid_o);
        end
        send_byte(8'h01);
        repeat (15) @(negedge clock);
        send_byte(8'h02);
        checks++; if (timeout_o !== 1'b0) begin errors++;
            $display("FAIL to_tick_wins: got %b required 0", timeout_o); end
        send_byte(8'h03); send_byte(8'h04);
        checks++; if (word_o !== 32'h0102_0304 || addr_o !== 10'd4) begin errors++;
            $display("FAIL to_expiry_word: got %h@%0d required 01020304@4", word_o, addr_o); end
    endtask
`else
    task automatic test_no_timeout;
        int pulses;
        word_ready_i = 1'b1;
        do_clear();
        send_byte(8'h12);
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (timeout_o !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++;
            $display("FAIL noto_pulse: got %0d pulses required 0", pulses); end
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        checks++; if (word_o !== 32'h1234_5678 || addr_o !== 10'd0 || word_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL noto_word: got %h@%0d v%b required 12345678@0 v1",
                     word_o, addr_o, word_valid_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_end_of_program();
        test_clear_in_done();
        test_reset_mid_word();
`ifdef RX_WORD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_word_packer.md
Name: rx_word_packer

Overview:
- Downstream consumer of the UART receiver's byte stream (`rx_done_tick` / `data_o`).
- Packs four consecutive received bytes into one 32-bit word, tags it with an auto-incrementing byte address and presents it to the loader/memory side over a valid/ready handshake.
- Detects an end-of-program word and stops loading; flags overruns, and optionally flags inter-byte timeouts.

Parameters:
- N_BITS_DATA, 8, byte width from the receiver; fixed at 8, the word is 4 bytes.
- ADDR_W, 10, width of the byte address output.
- END_WORD, 32'hFFFF_FFFF, word value that marks end of program.
- TIMEOUT_CYCLES, 100000, maximum clock cycles allowed between bytes of one word. Used only with the optional feature.

Ports:
- clock  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- rx_done_tick  input  1  one-cycle pulse from the receiver: byte valid on `data_i`.
- data_i  input  N_BITS_DATA  received byte.
- clear_i  input  1  synchronous restart of the loading session.
- word_ready_i  input  1  consumer accepts `word_o` when high together with `word_valid_o`.
- word_valid_o  output  1  `word_o` / `addr_o` hold a valid word.
- word_o  output  32  packed word, first received byte in bits [31:24].
- addr_o  output  ADDR_W  byte address of `word_o`; bits [1:0] are always 0.
- done_o  output  1  end word transferred; loading stopped.
- overrun_o  output  1  sticky: a completed word was dropped.
- timeout_o  output  1  one-cycle pulse: partial word discarded.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, byte counter 0, address counter 0, state IDLE.

State machine:
- IDLE: byte counter = 0. A tick stores a byte and moves to COLLECT.
- COLLECT: byte counter 1..3. Each tick stores a byte and increments the counter.
- DONE: all ticks ignored. Only `clear_i` or reset leave this state.

Byte storage:
- Each accepted tick shifts the byte in: shift <= {shift[23:0], data_i}.

Word completion (tick with byte counter = 3):
- Counter returns to 0 and the state goes to IDLE.
- If the output slot is free (word_valid_o = 0) or being transferred this cycle (word_valid_o & word_ready_i):
  - `word_o` <= complete word and `addr_o` <= address counter on the next edge; `word_valid_o` = 1.
  - Address counter += 4, wrapping modulo 2^ADDR_W.
- Otherwise the word is dropped, `overrun_o` is set to 1 (sticky) and the address counter is unchanged.

Handshake:
- `word_valid_o` stays high, with `word_o` / `addr_o` stable, until a cycle where `word_ready_i` = 1.
- After that cycle `word_valid_o` falls, unless a new word loads in the same cycle.
- Latency: `word_valid_o` rises on the edge after the 4th tick.

End of program:
- When the word loaded into the output register equals END_WORD, the state goes to DONE and further bytes are ignored.
- The END_WORD word itself is still presented and transferred.
- `done_o` rises on the edge after its transfer (valid & ready).

`clear_i`:
- Next edge: byte counter = 0, address counter = 0, `word_valid_o` = 0, `done_o` = 0, `overrun_o` = 0, state IDLE.
- Has priority over a simultaneous tick (that byte is lost) and over any pending word.

Reset mid-word: the partial word is lost; no output is asserted.

Optional Feature:
- Macro: RX_WORD_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in COLLECT and is cleared by every accepted tick.
  - When it reaches TIMEOUT_CYCLES-1 with no tick: byte counter = 0, state IDLE, `timeout_o` pulses high for one cycle, address unchanged.
  - A tick in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
- Undefined: no counter; a partial word waits indefinitely; `timeout_o` is tied to 0.

Test Plan:
- Reset, then ticks with 0x12, 0x34, 0x56, 0x78, word_ready_i = 1 -> one cycle after the 4th tick: word_valid_o = 1, word_o = 0x12345678, addr_o = 0. Next word of 0xAA, 0xBB, 0xCC, 0xDD -> word_o = 0xAABBCCDD, addr_o = 4.
- word_ready_i = 0; send 8 bytes (0x01..0x08) -> word_o holds 0x01020304 at addr 0; the second word is dropped and overrun_o = 1. Raise ready -> transfer, word_valid_o = 0, overrun_o stays 1 until clear_i.
- Send 0x00000001 then 0xFFFFFFFF, ready = 1 -> both transferred at addr 0 and 4, done_o = 1 after the second; further bytes 0x11×4 produce no word_valid_o.
- Send 2 bytes, pulse reset low asynchronously -> all outputs 0 immediately. Then 4 bytes 0xDEADBEEF -> word_o = 0xDEADBEEF, addr_o = 0.
- clear_i and rx_done_tick in the same cycle while in DONE, with overrun_o = 1 -> done_o = 0, overrun_o = 0, byte ignored; the next 4 bytes yield addr_o = 0.
- (RX_WORD_TIMEOUT_EN, TIMEOUT_CYCLES = 16) Send 0x12, wait 16 cycles -> timeout_o pulses. Then 0x9A, 0xBC, 0xDE, 0xF0 -> word_o = 0x9ABCDEF0; a tick exactly at expiry gives no timeout.
